// File: rtl/perf_counter_unit.sv
// Core performance counters with a memory-mapped clear/freeze control word.
// Counters wrap at WIDTH bits and raise a sticky per-counter overflow flag.
module perf_counter_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [31:0] CTRL_ADDR = 32'h5014
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble,
  input  logic        retire,
  input  logic        branch_resolved,
  input  logic        branch_correct,
  input  logic        MemWrite,
  input  logic [31:0] addrb,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs2_data,
  output logic [31:0] clk_cycles,
  output logic [31:0] invalid_clk_cycles,
  output logic [31:0] retired_instructions,
  output logic [31:0] correct_predictions,
  output logic [31:0] total_predictions,
  output logic        perf_frozen,
  output logic [4:0]  perf_overflow
);

  localparam int unsigned NUM_CNT = 5;
  localparam logic [2:0]  FUNCT3_SW = 3'b010;

  logic [NUM_CNT-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_CNT-1:0]            ovf_q, ovf_d;
  logic [NUM_CNT-1:0]            event_v;
  logic                          frozen_q, frozen_d;
  logic                          ctrl_we;
  logic                          clear;
  logic                          unused_rs2;

  // Only word stores hit the control register; byte/half stores are ignored.
  assign ctrl_we    = MemWrite && (addrb == CTRL_ADDR) && (funct3 == FUNCT3_SW);
  assign clear      = ctrl_we && rs2_data[0];
  assign unused_rs2 = ^rs2_data[31:2];

  // Bit order matches the output ports and perf_overflow.
  assign event_v = {branch_resolved,
                    branch_resolved & branch_correct,
                    retire,
                    bubble,
                    1'b1};

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    frozen_d = frozen_q;
    if (ctrl_we) begin
      frozen_d = rs2_data[1];
    end
    if (clear) begin
      cnt_d = '0;
      ovf_d = '0;
    end else if (!frozen_q) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (event_v[i]) begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
          if (&cnt_q[i]) begin
            ovf_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      cnt_q    <= '0;
      ovf_q    <= '0;
      frozen_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      frozen_q <= frozen_d;
    end
  end

  assign clk_cycles           = 32'(cnt_q[0]);
  assign invalid_clk_cycles   = 32'(cnt_q[1]);
  assign retired_instructions = 32'(cnt_q[2]);
  assign correct_predictions  = 32'(cnt_q[3]);
  assign total_predictions    = 32'(cnt_q[4]);
  assign perf_frozen          = frozen_q;
  assign perf_overflow        = ovf_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Bench for perf_counter_unit: a 32-bit and a 4-bit instance share stimulus and
// are compared every cycle against unbounded event tallies reduced modulo 2**WIDTH.
module tb_perf_counter_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        bubble, retire, branch_resolved, branch_correct;
  logic        MemWrite;
  logic [31:0] addrb;
  logic [2:0]  funct3;
  logic [31:0] rs2_data;

  logic [4:0][31:0] o32, o4;
  logic             frz32, frz4;
  logic [4:0]       ovf32, ovf4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  perf_counter_unit #(.WIDTH(32), .CTRL_ADDR(32'h5014)) dut32 (
    .clk(clk), .rst(rst), .bubble(bubble), .retire(retire),
    .branch_resolved(branch_resolved), .branch_correct(branch_correct),
    .MemWrite(MemWrite), .addrb(addrb), .funct3(funct3), .rs2_data(rs2_data),
    .clk_cycles(o32[0]), .invalid_clk_cycles(o32[1]), .retired_instructions(o32[2]),
    .correct_predictions(o32[3]), .total_predictions(o32[4]),
    .perf_frozen(frz32), .perf_overflow(ovf32)
  );

  perf_counter_unit #(.WIDTH(4), .CTRL_ADDR(32'h5014)) dut4 (
    .clk(clk), .rst(rst), .bubble(bubble), .retire(retire),
    .branch_resolved(branch_resolved), .branch_correct(branch_correct),
    .MemWrite(MemWrite), .addrb(addrb), .funct3(funct3), .rs2_data(rs2_data),
    .clk_cycles(o4[0]), .invalid_clk_cycles(o4[1]), .retired_instructions(o4[2]),
    .correct_predictions(o4[3]), .total_predictions(o4[4]),
    .perf_frozen(frz4), .perf_overflow(ovf4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: events counted since the last clear/reset, without any width limit.
  longint m_cnt [5];
  bit     m_frz   = 1'b0;
  bit     m_valid = 1'b0;

  always @(posedge clk) begin
    bit ev [5];
    bit we;
    ev[0] = 1'b1;
    ev[1] = bubble;
    ev[2] = retire;
    ev[3] = branch_resolved && branch_correct;
    ev[4] = branch_resolved;
    we = MemWrite && addrb == 32'h5014 && funct3 == 3'b010;
    if (rst) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_frz   = 1'b0;
      m_valid = 1'b1;
    end else begin
      if (we && rs2_data[0]) begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
      end else if (!m_frz) begin
        foreach (m_cnt[i]) if (ev[i]) m_cnt[i] = m_cnt[i] + 1;
      end
      if (we) m_frz = rs2_data[1];
    end
  end

  function automatic logic [31:0] exp_cnt(input longint c, input int w);
    return 32'(c % (longint'(1) << w));
  endfunction

  function automatic logic [4:0] exp_ovf(input int w);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = (m_cnt[i] >= (longint'(1) << w));
    return r;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("cmp_w32_cnt%0d", i), o32[i], exp_cnt(m_cnt[i], 32));
        check($sformatf("cmp_w4_cnt%0d", i), o4[i], exp_cnt(m_cnt[i], 4));
      end
      check("cmp_w32_ovf", 32'(ovf32), 32'(exp_ovf(32)));
      check("cmp_w4_ovf", 32'(ovf4), 32'(exp_ovf(4)));
      check("cmp_w32_frz", 32'(frz32), 32'(m_frz));
      check("cmp_w4_frz", 32'(frz4), 32'(m_frz));
    end
  end

  task automatic cyc(input logic b, input logic r, input logic br, input logic bc);
    bubble = b; retire = r; branch_resolved = br; branch_correct = bc;
    MemWrite = 1'b0; addrb = 32'h0; funct3 = 3'b000; rs2_data = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d,
                       input logic b, input logic r, input logic br);
    bubble = b; retire = r; branch_resolved = br; branch_correct = br;
    MemWrite = 1'b1; addrb = a; funct3 = f3; rs2_data = d;
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  task automatic at_negedge();
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    bubble = 1'b0; retire = 1'b0; branch_resolved = 1'b0; branch_correct = 1'b0;
    MemWrite = 1'b0; addrb = 32'h0; funct3 = 3'b000; rs2_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    at_negedge();
    check("rst_clk", o32[0], 32'd0);
    check("rst_frz", 32'(frz32), 32'd0);
    check("rst_ovf", 32'(ovf32), 32'd0);
    rst = 1'b0;

    // T1: 10 retiring cycles.
    repeat (10) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    at_negedge();
    check("t1_clk", o32[0], 32'd10);
    check("t1_retired", o32[2], 32'd10);
    check("t1_invalid", o32[1], 32'd0);
    check("t1_ovf", 32'(ovf32), 32'd0);

    // T2: 4 resolutions (3 correct), 2 unqualified correct pulses. Cycle 16 wraps the 4-bit clk.
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    at_negedge();
    check("t2_total", o32[4], 32'd4);
    check("t2_correct", o32[3], 32'd3);
    check("t5_w4_clk_wrap", o4[0], 32'd0);
    check("t5_w4_ovf", 32'(ovf4), 32'h01);

    // T3: freeze; the write cycle still counts.
    store(32'h5014, 3'b010, 32'h2, 1'b0, 1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    at_negedge();
    check("t3_retired_frozen", o32[2], 32'd11);
    check("t3_clk_frozen", o32[0], 32'd17);
    check("t3_frz", 32'(frz32), 32'd1);
    store(32'h5014, 3'b010, 32'h0, 1'b0, 1'b1, 1'b0);
    at_negedge();
    check("t3_unfreeze_cycle", o32[2], 32'd11);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    at_negedge();
    check("t3_resumed", o32[2], 32'd12);

    // T4: byte store and wrong address are ignored; word clear wins over events.
    store(32'h5014, 3'b000, 32'h1, 1'b0, 1'b1, 1'b0);
    at_negedge();
    check("t4_sb_ignored", o32[2], 32'd13);
    store(32'h5010, 3'b010, 32'h3, 1'b0, 1'b1, 1'b0);
    at_negedge();
    check("t4_addr_ignored", o32[0], 32'd20);
    check("t4_addr_no_frz", 32'(frz32), 32'd0);
    check("t5_ovf_persists", 32'(ovf4), 32'h01);
    store(32'h5014, 3'b010, 32'h1, 1'b1, 1'b1, 1'b1);
    at_negedge();
    check("t4_clear_clk", o32[0], 32'd0);
    check("t4_clear_retired", o32[2], 32'd0);
    check("t4_clear_total", o32[4], 32'd0);
    check("t5_clear_ovf", 32'(ovf4), 32'h00);

    // Clear together with freeze, then release.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    store(32'h5014, 3'b010, 32'h3, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    at_negedge();
    check("clrfrz_clk", o32[0], 32'd0);
    check("clrfrz_frz", 32'(frz32), 32'd1);
    store(32'h5014, 3'b010, 32'h0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    at_negedge();
    check("unfrz_clk", o32[0], 32'd1);

    // All counters of the 4-bit instance wrap together.
    repeat (15) cyc(1'b1, 1'b1, 1'b1, 1'b1);
    at_negedge();
    check("wrap_all_w4_ovf", 32'(ovf4), 32'h1f);
    check("wrap_all_w4_total", o4[4], 32'd0);
    check("wrap_all_w32_total", o32[4], 32'd16);

    // T6: reset mid-run with events active and freeze set.
    store(32'h5014, 3'b010, 32'h2, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    at_negedge();
    check("t6_clk", o32[0], 32'd0);
    check("t6_correct", o32[3], 32'd0);
    check("t6_frz", 32'(frz32), 32'd0);
    check("t6_w4_ovf", 32'(ovf4), 32'h00);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    at_negedge();
    check("post_rst_clk", o32[0], 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
